// File: rtl/icache_tag_ctrl_pkg.sv
// Shared types for the L1.5 icache tag-port controller: FSM state encoding
// and the tag entry packing helper ({valid, tag}).
package icache_tag_ctrl_pkg;

    localparam int unsigned TAG_FN_W = 64;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_SWEEP = 2'd1,
        ST_IDLE  = 2'd2
    } state_t;

    // Places the valid flag at bit (width-1) above a right-aligned tag.
    function automatic logic [TAG_FN_W-1:0] tag_entry(
        input logic                valid,
        input logic [TAG_FN_W-2:0] tag,
        input int unsigned         width
    );
        return ({{(TAG_FN_W-1){1'b0}}, valid} << (width - 1)) | {1'b0, tag};
    endfunction

endpackage

// File: rtl/icache_tag_ctrl.sv
// Tag RAM port controller: invalidating sweep after reset/flush, flush > refill > lookup arbitration,
// lookup hit one cycle after grant; requesters stall (hold request) until their grant is seen.
module icache_tag_ctrl
    import icache_tag_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 7,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_req_i,
    output logic                  flush_ack_o,
    input  logic                  refill_req_i,
    output logic                  refill_gnt_o,
    input  logic [ADDR_WIDTH-1:0] refill_addr_i,
    input  logic [DATA_WIDTH-2:0] refill_tag_i,
    input  logic                  lookup_req_i,
    output logic                  lookup_gnt_o,
    input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
    input  logic [DATA_WIDTH-2:0] lookup_tag_i,
    output logic                  lookup_rvalid_o,
    output logic                  lookup_hit_o,
    output logic                  tag_req_o,
    output logic                  tag_write_o,
    output logic [ADDR_WIDTH-1:0] tag_addr_o,
    output logic [DATA_WIDTH-1:0] tag_wdata_o,
    input  logic [DATA_WIDTH-1:0] tag_rdata_i
);

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_flush_pend;
    logic                  r_flush_ack;
    logic                  r_lkp_vld;
    logic [DATA_WIDTH-2:0] r_lkp_tag;

    logic                  w_req;
    logic                  w_write;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_refill_gnt;
    logic                  w_lookup_gnt;
    logic [DATA_WIDTH-1:0] w_refill_entry;
    logic [DATA_WIDTH-1:0] w_invalid_entry;

    assign w_refill_entry  = DATA_WIDTH'(tag_entry(1'b1, (TAG_FN_W-1)'(refill_tag_i), DATA_WIDTH));
    assign w_invalid_entry = DATA_WIDTH'(tag_entry(1'b0, '0, DATA_WIDTH));

    // RAM port and grants are combinational so a grant and its RAM access share a cycle.
    always_comb begin
        w_req        = 1'b0;
        w_write      = 1'b0;
        w_addr       = '0;
        w_wdata      = '0;
        w_refill_gnt = 1'b0;
        w_lookup_gnt = 1'b0;
        case (r_state)
            ST_SWEEP: begin
                w_req   = 1'b1;
                w_write = 1'b1;
                w_addr  = r_cnt;
                w_wdata = w_invalid_entry;
            end
            ST_IDLE: begin
                if (flush_req_i) begin
                    w_req = 1'b0;
                end else if (refill_req_i) begin
                    w_req        = 1'b1;
                    w_write      = 1'b1;
                    w_addr       = refill_addr_i;
                    w_wdata      = w_refill_entry;
                    w_refill_gnt = 1'b1;
                end else if (lookup_req_i) begin
                    w_req        = 1'b1;
                    w_addr       = lookup_addr_i;
                    w_lookup_gnt = 1'b1;
                end
            end
            default: w_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RST;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_flush_ack  <= 1'b0;
            r_lkp_vld    <= 1'b0;
            r_lkp_tag    <= '0;
        end else begin
            r_flush_ack <= 1'b0;
            r_lkp_vld   <= w_lookup_gnt;
            if (w_lookup_gnt) begin
                r_lkp_tag <= lookup_tag_i;
            end
            case (r_state)
                ST_RST: begin
                    r_state      <= ST_SWEEP;
                    r_cnt        <= '0;
                    r_flush_pend <= 1'b0;
                end
                ST_SWEEP: begin
                    if (flush_req_i) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (r_cnt == CNT_LAST) begin
                        // A flush seen during any part of this sweep is covered by it.
                        r_state      <= ST_IDLE;
                        r_flush_ack  <= r_flush_pend | flush_req_i;
                        r_flush_pend <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (flush_req_i) begin
                        r_state      <= ST_SWEEP;
                        r_cnt        <= '0;
                        r_flush_pend <= 1'b1;
                    end
                end
                default: r_state <= ST_RST;
            endcase
        end
    end

    assign flush_ack_o     = r_flush_ack;
    assign refill_gnt_o    = w_refill_gnt;
    assign lookup_gnt_o    = w_lookup_gnt;
    assign lookup_rvalid_o = r_lkp_vld;
    assign lookup_hit_o    = r_lkp_vld & tag_rdata_i[DATA_WIDTH-1]
                           & (tag_rdata_i[DATA_WIDTH-2:0] == r_lkp_tag);
    assign tag_req_o       = w_req;
    assign tag_write_o     = w_write;
    assign tag_addr_o      = w_addr;
    assign tag_wdata_o     = w_wdata;

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Bench for icache_tag_ctrl: behavioural tag RAM, table-driven arbitration vectors,
// scoreboard of expected lookup hits, and hand sequences for sweep/flush/reset corners.
module tb_icache_tag_ctrl;

    localparam int DW = 7;
    localparam int AW = 6;
    localparam int NSET = 2**AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush_req_i = 1'b0;
    logic          flush_ack_o;
    logic          refill_req_i = 1'b0;
    logic          refill_gnt_o;
    logic [AW-1:0] refill_addr_i = '0;
    logic [DW-2:0] refill_tag_i = '0;
    logic          lookup_req_i = 1'b0;
    logic          lookup_gnt_o;
    logic [AW-1:0] lookup_addr_i = '0;
    logic [DW-2:0] lookup_tag_i = '0;
    logic          lookup_rvalid_o;
    logic          lookup_hit_o;
    logic          tag_req_o;
    logic          tag_write_o;
    logic [AW-1:0] tag_addr_o;
    logic [DW-1:0] tag_wdata_o;
    logic [DW-1:0] tag_rdata_i;

    int n_chk = 0;
    int n_err = 0;

    icache_tag_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .flush_req_i(flush_req_i), .flush_ack_o(flush_ack_o),
        .refill_req_i(refill_req_i), .refill_gnt_o(refill_gnt_o),
        .refill_addr_i(refill_addr_i), .refill_tag_i(refill_tag_i),
        .lookup_req_i(lookup_req_i), .lookup_gnt_o(lookup_gnt_o),
        .lookup_addr_i(lookup_addr_i), .lookup_tag_i(lookup_tag_i),
        .lookup_rvalid_o(lookup_rvalid_o), .lookup_hit_o(lookup_hit_o),
        .tag_req_o(tag_req_o), .tag_write_o(tag_write_o),
        .tag_addr_o(tag_addr_o), .tag_wdata_o(tag_wdata_o),
        .tag_rdata_i(tag_rdata_i)
    );

    always #5 clk = ~clk;

    // Synchronous tag RAM; seeded with valid entries (tag = index) while in reset.
    logic [DW-1:0] mem [NSET];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NSET; i++) mem[i] <= {1'b1, 6'(i)};
        end else if (tag_req_o) begin
            if (tag_write_o) mem[tag_addr_o] <= tag_wdata_o;
            else             tag_rdata_i    <= mem[tag_addr_o];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Independent cache-content model feeding the hit scoreboard.
    logic          model_v [NSET];
    logic [DW-2:0] model_t [NSET];
    bit            sb [$];
    logic          prev_lgnt = 1'b0;

    task automatic model_clear();
        for (int i = 0; i < NSET; i++) begin
            model_v[i] = 1'b0;
            model_t[i] = '0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_lgnt = 1'b0;
        end else begin
            chk("rvalid_after_grant", lookup_rvalid_o, prev_lgnt);
            if (lookup_rvalid_o) begin
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else                chk("lookup_hit", lookup_hit_o, sb.pop_front());
            end
            prev_lgnt = lookup_gnt_o;
            if (lookup_gnt_o)
                sb.push_back(model_v[lookup_addr_i] && (model_t[lookup_addr_i] == lookup_tag_i));
            if (refill_gnt_o) begin
                model_v[refill_addr_i] = 1'b1;
                model_t[refill_addr_i] = refill_tag_i;
            end
        end
    end

    typedef struct {
        logic          rr;
        logic [AW-1:0] ra;
        logic [DW-2:0] rt;
        logic          lr;
        logic [AW-1:0] la;
        logic [DW-2:0] lt;
        logic          eg_r;
        logic          eg_l;
    } vec_t;
    vec_t vt [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_lookup(input logic [AW-1:0] a, input logic [DW-2:0] t);
        lookup_req_i = 1'b1; lookup_addr_i = a; lookup_tag_i = t;
        @(negedge clk);
        chk("do_lookup_gnt", lookup_gnt_o, 1);
        tick();
        lookup_req_i = 1'b0;
    endtask

    // Cycle count from request cycle to ack cycle; drops flush on seeing ack.
    task automatic wait_ack(input int bound, output int cyc);
        logic got;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < bound) begin
            tick();
            cyc++;
            if (flush_ack_o) begin
                got = 1'b1;
                flush_req_i = 1'b0;
            end
        end
        if (!got) chk("flush_ack_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        int cyc, acks, ack_at;
        logic [AW-1:0] exp_addr;

        vt[0]  = '{1, 5,  6'h2A, 0, 0,  6'h00, 1, 0};
        vt[1]  = '{0, 0,  6'h00, 1, 5,  6'h2A, 0, 1};
        vt[2]  = '{0, 0,  6'h00, 1, 5,  6'h2B, 0, 1};
        vt[3]  = '{0, 0,  6'h00, 1, 6,  6'h2A, 0, 1};
        vt[4]  = '{1, 9,  6'h11, 0, 0,  6'h00, 1, 0};
        vt[5]  = '{1, 12, 6'h05, 1, 9,  6'h11, 1, 0};
        vt[6]  = '{0, 0,  6'h00, 1, 9,  6'h11, 0, 1};
        vt[7]  = '{0, 0,  6'h00, 1, 12, 6'h05, 0, 1};
        vt[8]  = '{0, 0,  6'h00, 0, 0,  6'h00, 0, 0};
        vt[9]  = '{0, 0,  6'h00, 1, 0,  6'h00, 0, 1};
        vt[10] = '{1, 63, 6'h3F, 0, 0,  6'h00, 1, 0};
        vt[11] = '{0, 0,  6'h00, 1, 63, 6'h3F, 0, 1};
        model_clear();

        // Reset and init sweep, with a lookup held pending throughout.
        lookup_req_i = 1'b1; lookup_addr_i = 3; lookup_tag_i = 6'h03;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tag_req", tag_req_o, 0);
        chk("rst_flush_ack", flush_ack_o, 0);
        chk("rst_lgnt", lookup_gnt_o, 0);
        chk("rst_rvalid", lookup_rvalid_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rststate_tag_req", tag_req_o, 0);
        chk("rststate_lgnt", lookup_gnt_o, 0);
        tick();
        for (int i = 0; i < NSET; i++) begin
            @(negedge clk);
            chk("sweep_req", tag_req_o, 1);
            chk("sweep_write", tag_write_o, 1);
            chk("sweep_addr", tag_addr_o, i);
            chk("sweep_wdata", tag_wdata_o, 0);
            chk("sweep_lgnt", lookup_gnt_o, 0);
            chk("sweep_ack", flush_ack_o, 0);
            tick();
        end
        @(negedge clk);
        chk("first_lookup_gnt_cycle65", lookup_gnt_o, 1);
        tick();
        lookup_req_i = 1'b0;

        // Arbitration table.
        for (int k = 0; k < 12; k++) begin
            refill_req_i = vt[k].rr; refill_addr_i = vt[k].ra; refill_tag_i = vt[k].rt;
            lookup_req_i = vt[k].lr; lookup_addr_i = vt[k].la; lookup_tag_i = vt[k].lt;
            @(negedge clk);
            exp_addr = vt[k].eg_r ? vt[k].ra : (vt[k].eg_l ? vt[k].la : '0);
            chk($sformatf("vec%0d_rgnt", k), refill_gnt_o, vt[k].eg_r);
            chk($sformatf("vec%0d_lgnt", k), lookup_gnt_o, vt[k].eg_l);
            chk($sformatf("vec%0d_req", k), tag_req_o, vt[k].eg_r | vt[k].eg_l);
            chk($sformatf("vec%0d_write", k), tag_write_o, vt[k].eg_r);
            chk($sformatf("vec%0d_addr", k), tag_addr_o, exp_addr);
            if (vt[k].eg_r) chk($sformatf("vec%0d_wdata", k), tag_wdata_o, {1'b1, vt[k].rt});
            tick();
        end
        refill_req_i = 1'b0; lookup_req_i = 1'b0;

        // Flush invalidates previously refilled sets.
        flush_req_i = 1'b1;
        model_clear();
        @(negedge clk);
        chk("flush_req_cycle_no_access", tag_req_o, 0);
        wait_ack(200, cyc);
        chk("flush_ack_latency", cyc, 65);
        @(negedge clk);
        chk("flush_ack_pulse", flush_ack_o, 1);
        tick();
        chk("flush_ack_single", flush_ack_o, 0);
        do_lookup(5, 6'h2A);
        do_lookup(9, 6'h11);

        // Flush, refill and lookup together: sweep first, then refill before lookup.
        flush_req_i = 1'b1;
        refill_req_i = 1'b1; refill_addr_i = 20; refill_tag_i = 6'h15;
        lookup_req_i = 1'b1; lookup_addr_i = 20; lookup_tag_i = 6'h15;
        model_clear();
        @(negedge clk);
        chk("all3_rgnt", refill_gnt_o, 0);
        chk("all3_lgnt", lookup_gnt_o, 0);
        chk("all3_tag_req", tag_req_o, 0);
        wait_ack(200, cyc);
        chk("all3_ack_latency", cyc, 65);
        @(negedge clk);
        chk("all3_rgnt_after_ack", refill_gnt_o, 1);
        chk("all3_lgnt_after_ack", lookup_gnt_o, 0);
        tick();
        refill_req_i = 1'b0;
        @(negedge clk);
        chk("all3_lgnt_second", lookup_gnt_o, 1);
        tick();
        lookup_req_i = 1'b0;

        // Flush re-pulsed mid-sweep: one ack, no second sweep.
        flush_req_i = 1'b1;
        model_clear();
        acks = 0; ack_at = 0;
        for (int c = 1; c <= 80; c++) begin
            tick();
            flush_req_i = (c == 21);
            if (c == 21) chk("repulse_sweep_addr", tag_addr_o, 20);
            if (flush_ack_o) begin
                acks++;
                ack_at = c;
            end
        end
        chk("repulse_ack_count", acks, 1);
        chk("repulse_ack_at", ack_at, 65);
        chk("repulse_idle_after", tag_req_o, 0);

        // Reset mid-sweep at address 30.
        flush_req_i = 1'b1;
        model_clear();
        cyc = 0;
        while (cyc < 100) begin
            tick();
            cyc++;
            if (tag_req_o && tag_write_o && tag_addr_o == 30) break;
        end
        chk("midrst_reached_addr30", tag_addr_o, 30);
        rst_n = 1'b0;
        flush_req_i = 1'b0;
        #1;
        chk("midrst_req", tag_req_o, 0);
        chk("midrst_write", tag_write_o, 0);
        chk("midrst_addr", tag_addr_o, 0);
        chk("midrst_ack", flush_ack_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_rststate_req", tag_req_o, 0);
        tick();
        @(negedge clk);
        chk("midrst_restart_addr0", tag_addr_o, 0);
        chk("midrst_restart_req", tag_req_o, 1);
        acks = 0;
        for (int c = 0; c < 70; c++) begin
            tick();
            if (flush_ack_o) acks++;
        end
        chk("midrst_no_ack", acks, 0);
        do_lookup(63, 6'h3F);
        do_lookup(20, 6'h15);

        repeat (3) tick();
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
